// File: rtl/fmdll_sar_ctrl.sv
// FMDLL delay-code controller: SAR acquisition then +/-1 tracking with lock detect.
// Optional FMDLL_LOCK_HOLD_EN freezes code and lock once locked.
module fmdll_sar_ctrl #(
  parameter int CODE_W     = 6,
  parameter int SETTLE_CYC = 2,
  parameter int LOCK_CNT   = 4
) (
  input  logic              clk_div,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pd_up,
  output logic [CODE_W-1:0] code,
  output logic              busy,
  output logic              sar_done,
  output logic              locked
);

  localparam int BW = (CODE_W > 2) ? $clog2(CODE_W) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int RW = $clog2(LOCK_CNT + 1);

  localparam logic [CODE_W-1:0] MID = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [CODE_W-1:0] ONE = CODE_W'(1);
  localparam logic [BW-1:0]     TOP = BW'(CODE_W - 1);
  localparam logic [SW-1:0]     SET = SW'(SETTLE_CYC);
  localparam logic [RW-1:0]     LCK = RW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    SAR,
    TRACK
  } state_t;

  state_t            state;
  logic [BW-1:0]     bit_idx;
  logic [SW-1:0]     settle_cnt;
  logic [RW-1:0]     rev_cnt;
  logic              last_dir;

  logic [CODE_W-1:0] sar_nxt;
  logic [CODE_W-1:0] trk_nxt;
  logic [CODE_W:0]   inc;
  logic              hold;

  // trial bit resolved by pd_up, next lower bit raised for its trial
  always_comb begin
    sar_nxt = code;
    if (!pd_up) sar_nxt[bit_idx] = 1'b0;
    if (bit_idx != '0) sar_nxt[bit_idx - BW'(1)] = 1'b1;
  end

  assign inc = {1'b0, code} + {{CODE_W{1'b0}}, 1'b1};

  always_comb begin
    trk_nxt = code;
    if (pd_up) begin
      if (!inc[CODE_W]) trk_nxt = inc[CODE_W-1:0];
    end else if (code != '0) begin
      trk_nxt = code - ONE;
    end
  end

`ifdef FMDLL_LOCK_HOLD_EN
  assign hold = locked;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      code       <= MID;
      busy       <= 1'b0;
      sar_done   <= 1'b0;
      locked     <= 1'b0;
      bit_idx    <= TOP;
      settle_cnt <= '0;
      rev_cnt    <= '0;
      last_dir   <= 1'b0;
    end else begin
      sar_done <= 1'b0;
      if (start) begin
        state      <= SAR;
        code       <= MID;
        bit_idx    <= TOP;
        settle_cnt <= SET;
        busy       <= 1'b1;
        locked     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          SAR: begin
            if (settle_cnt != '0) begin
              settle_cnt <= settle_cnt - SW'(1);
            end else begin
              code       <= sar_nxt;
              settle_cnt <= SET;
              if (bit_idx != '0) begin
                bit_idx <= bit_idx - BW'(1);
              end else begin
                state    <= TRACK;
                busy     <= 1'b0;
                sar_done <= 1'b1;
                rev_cnt  <= '0;
                last_dir <= pd_up;
              end
            end
          end
          TRACK: begin
            if (settle_cnt != '0) begin
              settle_cnt <= settle_cnt - SW'(1);
            end else begin
              settle_cnt <= SET;
              last_dir   <= pd_up;
              if (!hold) begin
                code <= trk_nxt;
                if (pd_up != last_dir) begin
                  if (rev_cnt != LCK) rev_cnt <= rev_cnt + RW'(1);
                  if (rev_cnt >= LCK - RW'(1)) locked <= 1'b1;
                end else begin
                  rev_cnt <= '0;
                  locked  <= 1'b0;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
